muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 169 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: MULT, MULTU, DIV, DIVU.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes,
// followed by a one-cycle sign-correction step.
// Optional feature macro: MULDIV_EARLY_ZERO_EN -- a divide by zero skips
// the iteration and completes right after acceptance.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            div_by_zero
);

  localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(XLEN - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [1:0]      op_r;
  logic [XLEN-1:0] a_r;
  logic [XLEN-1:0] mag_b;
  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] lo_r;
  logic            neg_res;
  logic            neg_rem;
  logic            b_zero;

  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] mag_a_in;
  logic [XLEN-1:0] mag_b_in;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;
  logic [XLEN-1:0] acc_next;
  logic [XLEN-1:0] lo_next;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0] res_hi;
  logic [XLEN-1:0] res_lo;
  logic            res_dbz;

  // Operand magnitudes at acceptance; op[0]=0 selects the signed variants
  always_comb begin
    a_neg    = ~op[0] & a[XLEN-1];
    b_neg    = ~op[0] & b[XLEN-1];
    mag_a_in = a_neg ? (~a + 1'b1) : a;
    mag_b_in = b_neg ? (~b + 1'b1) : b;
  end

  // One iteration: shift-add for multiply, restoring subtract-shift for divide
  always_comb begin
    mul_sum = {1'b0, acc} + {1'b0, (lo_r[0] ? mag_b : {XLEN{1'b0}})};
    shifted = {acc, lo_r[XLEN-1]};
    diff    = shifted - {1'b0, mag_b};
    if (op_r[1]) begin
      acc_next = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
      lo_next  = {lo_r[XLEN-2:0], ~diff[XLEN]};
    end else begin
      acc_next = mul_sum[XLEN:1];
      lo_next  = {mul_sum[0], lo_r[XLEN-1:1]};
    end
  end

  // Final results with sign correction; divide by zero overrides the datapath
  always_comb begin
    prod    = {acc, lo_r};
    res_hi  = '0;
    res_lo  = '0;
    res_dbz = 1'b0;
    if (op_r[1]) begin
      if (b_zero) begin
        res_hi  = a_r;
        res_lo  = '1;
        res_dbz = 1'b1;
      end else begin
        res_lo = neg_res ? (~lo_r + 1'b1) : lo_r;
        res_hi = neg_rem ? (~acc + 1'b1) : acc;
      end
    end else begin
      if (neg_res) prod = ~prod + 1'b1;
      res_hi = prod[2*XLEN-1:XLEN];
      res_lo = prod[XLEN-1:0];
    end
  end

  // Control FSM with registered busy/done and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      op_r        <= 2'b00;
      a_r         <= '0;
      mag_b       <= '0;
      acc         <= '0;
      lo_r        <= '0;
      neg_res     <= 1'b0;
      neg_rem     <= 1'b0;
      b_zero      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_r    <= op;
            a_r     <= a;
            mag_b   <= mag_b_in;
            acc     <= '0;
            lo_r    <= mag_a_in;
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            b_zero  <= (b == '0);
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
`ifdef MULDIV_EARLY_ZERO_EN
          if (op_r[1] && b_zero) begin
            hi          <= res_hi;
            lo          <= res_lo;
            div_by_zero <= res_dbz;
            done        <= 1'b1;
            state       <= DONE;
          end else begin
            acc <= acc_next;
            lo_r <= lo_next;
            cnt <= cnt + 1'b1;
            if (cnt == LAST_STEP) state <= FIX;
          end
`else
          acc  <= acc_next;
          lo_r <= lo_next;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST_STEP) state <= FIX;
`endif
        end
        FIX: begin
          hi          <= res_hi;
          lo          <= res_lo;
          div_by_zero <= res_dbz;
          done        <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// [TB] Self-checking bench for muldiv_unit (XLEN=32): directed vector table,
// randomized operations against an arithmetic reference model, and
// hand-written sequences for ignored starts and mid-operation reset.
module tb_muldiv_unit;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic            div_by_zero;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } res_t;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run can never hang
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model straight from the arithmetic definitions
  function automatic res_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    res_t r;
    longint sx, sy, q, m;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    r.dbz = 1'b0;
    case (o)
      2'd0: begin p = sx * sy; r.hi = p[63:32]; r.lo = p[31:0]; end
      2'd1: begin p = {32'b0, x} * {32'b0, y}; r.hi = p[63:32]; r.lo = p[31:0]; end
      default: begin
        if (y == 32'd0) begin
          r.hi = x; r.lo = 32'hFFFF_FFFF; r.dbz = 1'b1;
        end else if (o == 2'd2) begin
          q = sx / sy; m = sx % sy;
          p = q; r.lo = p[31:0];
          p = m; r.hi = p[31:0];
        end else begin
          r.lo = x / y; r.hi = x % y;
        end
      end
    endcase
    return r;
  endfunction

  // Edge after acceptance at which done first becomes visible
  function automatic int expected_rise(input logic [1:0] o, input logic [31:0] y);
`ifdef MULDIV_EARLY_ZERO_EN
    if (o[1] && y == 32'd0) return 1;
`endif
    return XLEN + 1;
  endfunction

  // Issue one op (inputs changed right after acceptance), wait for done,
  // optionally pulse start mid-flight, and try a start during the done cycle
  task automatic apply_stimulus(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                input bit pulses, output res_t got, output int rise);
    int n;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      if (busy !== 1'b1) begin
        checks++; fails++;
        $display("[TB] FAIL busy_in_flight: got %b expected 1 at cycle %0d", busy, n);
      end
      @(posedge clk); #1;
      n++;
      if (pulses && (n == 5 || n == 20)) begin
        start = 1'b1; op = 2'($urandom); a = $urandom; b = $urandom;
      end else begin
        start = 1'b0;
      end
    end
    rise = (done === 1'b1) ? n : -1;
    got.hi = hi; got.lo = lo; got.dbz = div_by_zero;
    start = 1'b1; op = 2'd1; a = 32'd9; b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    check_output("done_one_cycle", 64'(done), 64'd0);
    check_output("start_in_done_ignored", 64'(busy), 64'd0);
  endtask

  task automatic run_and_check(input string name, input logic [1:0] o, input logic [31:0] x,
                               input logic [31:0] y, input res_t exp);
    res_t got;
    int   rise;
    apply_stimulus(o, x, y, 1'b0, got, rise);
    check_output({name, "_latency"}, 64'(rise), 64'(expected_rise(o, y)));
    check_output({name, "_hi"}, 64'(got.hi), 64'(exp.hi));
    check_output({name, "_lo"}, 64'(got.lo), 64'(exp.lo));
    check_output({name, "_dbz"}, 64'(got.dbz), 64'(exp.dbz));
  endtask

  initial begin
    vec_t vecs[6];
    res_t exp;
    res_t got;
    res_t hold;
    int   rise;
    int   extra;

    vecs[0] = '{"multu_max",  2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[1] = '{"mult_neg3x5", 2'd0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
    vecs[2] = '{"div_m7_2",   2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[3] = '{"divu_by0",   2'd3, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1};
    vecs[4] = '{"div_ovf",    2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0};
    vecs[5] = '{"multu_2x3",  2'd1, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0};

    rst_n = 1'b0; start = 1'b0; op = 2'd0; a = '0; b = '0;
    #1;
    check_output("reset_busy", 64'(busy), 64'd0);
    check_output("reset_done", 64'(done), 64'd0);
    check_output("reset_hi", 64'(hi), 64'd0);
    check_output("reset_lo", 64'(lo), 64'd0);
    check_output("reset_dbz", 64'(div_by_zero), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed table; the first op is issued in the same slot as reset release
    for (int i = 0; i < 6; i++) begin
      exp.hi = vecs[i].hi; exp.lo = vecs[i].lo; exp.dbz = vecs[i].dbz;
      run_and_check(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, exp);
    end

    // Results hold while idle regardless of input activity
    hold.hi = hi; hold.lo = lo; hold.dbz = div_by_zero;
    for (int i = 0; i < 5; i++) begin
      op = 2'($urandom); a = $urandom; b = $urandom;
      @(posedge clk); #1;
    end
    check_output("hold_hi", 64'(hi), 64'(hold.hi));
    check_output("hold_lo", 64'(lo), 64'(hold.lo));

    // Randomized operations against the model
    for (int i = 0; i < 24; i++) begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      ro = 2'($urandom);
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'd0;
        1: rb = $urandom_range(1, 15);
        2: rb = -$urandom_range(1, 15);
        default: rb = $urandom;
      endcase
      if (i == 0) begin ro = 2'd2; rb = 32'd0; ra = 32'hF000_0001; end
      run_and_check($sformatf("rand%0d", i), ro, ra, rb, model(ro, ra, rb));
    end

    // Start pulses while busy must not disturb the op in flight
    exp = model(2'd3, 32'd1000, 32'd33);
    apply_stimulus(2'd3, 32'd1000, 32'd33, 1'b1, got, rise);
    check_output("ignored_start_latency", 64'(rise), 64'(XLEN + 1));
    check_output("ignored_start_hi", 64'(got.hi), 64'(exp.hi));
    check_output("ignored_start_lo", 64'(got.lo), 64'(exp.lo));
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) extra++;
    end
    check_output("ignored_start_single_done", 64'(extra), 64'd0);

    // Reset in the middle of DIVU 100/7 abandons it, then reissue
    start = 1'b1; op = 2'd3; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_output("midreset_busy", 64'(busy), 64'd0);
    check_output("midreset_done", 64'(done), 64'd0);
    check_output("midreset_hi", 64'(hi), 64'd0);
    check_output("midreset_lo", 64'(lo), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    check_output("midreset_no_done", 64'(extra), 64'd0);
    exp.hi = 32'd2; exp.lo = 32'd14; exp.dbz = 1'b0;
    run_and_check("reissue_divu", 2'd3, 32'd100, 32'd7, exp);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
